// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 8-bit pipelined core.
// Forwarded operands, single-cycle ALU, iterative shift-add multiply, EX/MEM register.
module ex_stage #(
  parameter int DATA_W     = 8,
  parameter int REG_W      = 5,
  parameter int MUL_CYCLES = DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_rs_data,
  input  logic [DATA_W-1:0] in_rt_data,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_alu_src,
  input  logic [3:0]        in_alu_op,
  input  logic [REG_W-1:0]  in_rd,
  input  logic              in_reg_write,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic [1:0]        forward_a,
  input  logic [1:0]        forward_b,
  input  logic [DATA_W-1:0] mem_fwd_data,
  input  logic [DATA_W-1:0] wb_fwd_data,
  input  logic              mem_stall,
  input  logic              flush,
  output logic              ex_busy,
  output logic              ex_mem_valid,
  output logic              ex_mem_reg_write,
  output logic              ex_mem_mem_read,
  output logic              ex_mem_mem_write,
  output logic [DATA_W-1:0] ex_mem_result,
  output logic [DATA_W-1:0] ex_mem_store_data,
  output logic [REG_W-1:0]  ex_mem_rd,
  output logic              ex_mem_zero,
  output logic              ex_mem_carry
);

  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLT   = 4'd5;
  localparam logic [3:0] OP_SHL   = 4'd6;
  localparam logic [3:0] OP_SHR   = 4'd7;
  localparam logic [3:0] OP_MUL   = 4'd8;
  localparam logic [3:0] OP_PASSB = 4'd9;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [DATA_W-1:0] acc;
  logic [REG_W-1:0]  mul_rd;
  logic              mul_rw;
  logic              mul_mr;
  logic              mul_mw;

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] rt_fwd;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] acc_next;
  logic              alu_carry;
  logic              is_mul;
  logic              last;

  function automatic logic [DATA_W-1:0] fwd(
    input logic [1:0]        sel,
    input logic [DATA_W-1:0] id_val,
    input logic [DATA_W-1:0] mem_val,
    input logic [DATA_W-1:0] wb_val
  );
    case (sel)
      2'b10:   return mem_val;
      2'b01:   return wb_val;
      default: return id_val;
    endcase
  endfunction

  assign op_a   = fwd(forward_a, in_rs_data, mem_fwd_data, wb_fwd_data);
  assign rt_fwd = fwd(forward_b, in_rt_data, mem_fwd_data, wb_fwd_data);
  assign op_b   = in_alu_src ? in_imm : rt_fwd;
  assign is_mul = (in_alu_op == OP_MUL);

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (in_alu_op)
      OP_ADD: {alu_carry, alu_res} = {1'b0, op_a} + {1'b0, op_b};
      OP_SUB: begin
        alu_res   = op_a - op_b;
        alu_carry = (op_a < op_b);
      end
      OP_AND:   alu_res = op_a & op_b;
      OP_OR:    alu_res = op_a | op_b;
      OP_XOR:   alu_res = op_a ^ op_b;
      OP_SLT:   alu_res = DATA_W'($signed(op_a) < $signed(op_b));
      OP_SHL:   alu_res = op_a << op_b[2:0];
      OP_SHR:   alu_res = op_a >> op_b[2:0];
      OP_PASSB: alu_res = op_b;
      default:  alu_res = '0;
    endcase
  end

  assign acc_next = mplier[0] ? (acc + mcand) : acc;
  assign last     = (state == RUN) && (cnt == CNT_LAST);

  // A stalled or unflushed MUL in IDLE still has to hold ID/EX.
  always_comb begin
    ex_busy = 1'b0;
    if (rst_n) begin
      if (state == RUN)
        ex_busy = !(last && !mem_stall);
      else
        ex_busy = in_valid && is_mul && (mem_stall || !flush);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      cnt               <= '0;
      mcand             <= '0;
      mplier            <= '0;
      acc               <= '0;
      mul_rd            <= '0;
      mul_rw            <= 1'b0;
      mul_mr            <= 1'b0;
      mul_mw            <= 1'b0;
      ex_mem_valid      <= 1'b0;
      ex_mem_reg_write  <= 1'b0;
      ex_mem_mem_read   <= 1'b0;
      ex_mem_mem_write  <= 1'b0;
      ex_mem_result     <= '0;
      ex_mem_store_data <= '0;
      ex_mem_rd         <= '0;
      ex_mem_zero       <= 1'b0;
      ex_mem_carry      <= 1'b0;
    end else if (!mem_stall) begin
      ex_mem_valid     <= 1'b0;
      ex_mem_reg_write <= 1'b0;
      ex_mem_mem_read  <= 1'b0;
      ex_mem_mem_write <= 1'b0;
      if (flush) begin
        state <= IDLE;
        cnt   <= '0;
      end else if (state == RUN) begin
        acc    <= acc_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (last) begin
          state            <= IDLE;
          ex_mem_valid     <= 1'b1;
          ex_mem_reg_write <= mul_rw;
          ex_mem_mem_read  <= mul_mr;
          ex_mem_mem_write <= mul_mw;
          ex_mem_rd        <= mul_rd;
          ex_mem_result    <= acc_next;
          ex_mem_zero      <= (acc_next == '0);
          ex_mem_carry     <= 1'b0;
        end
      end else if (in_valid && is_mul) begin
        state  <= RUN;
        cnt    <= '0;
        acc    <= '0;
        mcand  <= op_a;
        mplier <= op_b;
        mul_rd <= in_rd;
        mul_rw <= in_reg_write;
        mul_mr <= in_mem_read;
        mul_mw <= in_mem_write;
      end else if (in_valid) begin
        ex_mem_valid      <= 1'b1;
        ex_mem_reg_write  <= in_reg_write;
        ex_mem_mem_read   <= in_mem_read;
        ex_mem_mem_write  <= in_mem_write;
        ex_mem_rd         <= in_rd;
        ex_mem_result     <= alu_res;
        ex_mem_store_data <= rt_fwd;
        ex_mem_zero       <= (alu_res == '0);
        ex_mem_carry      <= alu_carry;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed bench for ex_stage.
// Expected EX/MEM contents are queued at issue and compared when valid appears.
module tb_ex_stage;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_rs_data;
  logic [7:0] in_rt_data;
  logic [7:0] in_imm;
  logic       in_alu_src;
  logic [3:0] in_alu_op;
  logic [4:0] in_rd;
  logic       in_reg_write;
  logic       in_mem_read;
  logic       in_mem_write;
  logic [1:0] forward_a;
  logic [1:0] forward_b;
  logic [7:0] mem_fwd_data;
  logic [7:0] wb_fwd_data;
  logic       mem_stall;
  logic       flush;
  logic       ex_busy;
  logic       ex_mem_valid;
  logic       ex_mem_reg_write;
  logic       ex_mem_mem_read;
  logic       ex_mem_mem_write;
  logic [7:0] ex_mem_result;
  logic [7:0] ex_mem_store_data;
  logic [4:0] ex_mem_rd;
  logic       ex_mem_zero;
  logic       ex_mem_carry;

  ex_stage dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_valid          (in_valid),
    .in_rs_data        (in_rs_data),
    .in_rt_data        (in_rt_data),
    .in_imm            (in_imm),
    .in_alu_src        (in_alu_src),
    .in_alu_op         (in_alu_op),
    .in_rd             (in_rd),
    .in_reg_write      (in_reg_write),
    .in_mem_read       (in_mem_read),
    .in_mem_write      (in_mem_write),
    .forward_a         (forward_a),
    .forward_b         (forward_b),
    .mem_fwd_data      (mem_fwd_data),
    .wb_fwd_data       (wb_fwd_data),
    .mem_stall         (mem_stall),
    .flush             (flush),
    .ex_busy           (ex_busy),
    .ex_mem_valid      (ex_mem_valid),
    .ex_mem_reg_write  (ex_mem_reg_write),
    .ex_mem_mem_read   (ex_mem_mem_read),
    .ex_mem_mem_write  (ex_mem_mem_write),
    .ex_mem_result     (ex_mem_result),
    .ex_mem_store_data (ex_mem_store_data),
    .ex_mem_rd         (ex_mem_rd),
    .ex_mem_zero       (ex_mem_zero),
    .ex_mem_carry      (ex_mem_carry)
  );

  typedef struct {
    logic [7:0] res;
    logic [7:0] store;
    logic [4:0] rd;
    logic       z;
    logic       c;
    logic       rw;
    logic       mr;
    logic       mw;
    logic       cs;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] res, input logic [7:0] store,
                      input logic [4:0] rd, input logic z, input logic c,
                      input logic rw, input logic mr, input logic mw,
                      input logic cs);
    exp_t e;
    e.res = res; e.store = store; e.rd = rd;
    e.z = z; e.c = c; e.rw = rw; e.mr = mr; e.mw = mw; e.cs = cs;
    sb.push_back(e);
  endtask

  task automatic tick(input logic ev);
    exp_t e;
    @(posedge clk);
    #1;
    chk("ex_mem_valid", 32'(ex_mem_valid), 32'(ev));
    if (ex_mem_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_depth", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        chk("result", 32'(ex_mem_result), 32'(e.res));
        chk("rd", 32'(ex_mem_rd), 32'(e.rd));
        chk("zero", 32'(ex_mem_zero), 32'(e.z));
        chk("carry", 32'(ex_mem_carry), 32'(e.c));
        chk("reg_write", 32'(ex_mem_reg_write), 32'(e.rw));
        chk("mem_read", 32'(ex_mem_mem_read), 32'(e.mr));
        chk("mem_write", 32'(ex_mem_mem_write), 32'(e.mw));
        if (e.cs) chk("store_data", 32'(ex_mem_store_data), 32'(e.store));
      end
    end
  endtask

  task automatic idle_in();
    in_valid = 0; in_rs_data = 0; in_rt_data = 0; in_imm = 0;
    in_alu_src = 0; in_alu_op = 0; in_rd = 0;
    in_reg_write = 0; in_mem_read = 0; in_mem_write = 0;
    forward_a = 0; forward_b = 0; mem_fwd_data = 0; wb_fwd_data = 0;
    mem_stall = 0; flush = 0;
  endtask

  task automatic set_mul(input logic [4:0] rd);
    idle_in();
    in_valid = 1; in_alu_op = 4'd8;
    in_rs_data = 8'h0D; in_rt_data = 8'h0B;
    in_rd = rd; in_reg_write = 1;
  endtask

  initial begin
    logic [3:0] t_op[9];
    logic [7:0] t_res[9];
    t_op  = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd1};
    t_res = '{8'h24, 8'hBD, 8'h99, 8'h01, 8'h50, 8'h0A, 8'h3C, 8'h00, 8'h69};

    idle_in();
    rst_n = 0;
    #12;
    chk("rst_valid", 32'(ex_mem_valid), 0);
    chk("rst_result", 32'(ex_mem_result), 0);
    chk("rst_rd", 32'(ex_mem_rd), 0);
    chk("rst_busy", 32'(ex_busy), 0);
    rst_n = 1;

    // ADD with EX/MEM forwarding on A
    in_valid = 1; in_alu_op = 0; in_rs_data = 8'h01; forward_a = 2'b10;
    mem_fwd_data = 8'h7F; in_rt_data = 8'h81; forward_b = 2'b00;
    in_rd = 5'd3; in_reg_write = 1;
    push(8'h00, 8'h81, 5'd3, 1, 1, 1, 0, 0, 1);
    #1 chk("busy_add", 32'(ex_busy), 0);
    tick(1);

    // SUB with MEM/WB forwarding on B
    idle_in();
    in_valid = 1; in_alu_op = 1; in_rs_data = 8'h03; mem_fwd_data = 8'h7F;
    forward_b = 2'b01; wb_fwd_data = 8'h05; in_rd = 5'd4; in_reg_write = 1;
    push(8'hFE, 8'h05, 5'd4, 0, 1, 1, 0, 0, 1);
    tick(1);
    forward_a = 2'b11;
    push(8'hFE, 8'h05, 5'd4, 0, 1, 1, 0, 0, 1);
    tick(1);

    // store: immediate operand, forwarded store data
    idle_in();
    in_valid = 1; in_alu_op = 0; in_rs_data = 8'h20; in_alu_src = 1;
    in_imm = 8'h10; forward_b = 2'b10; mem_fwd_data = 8'h3C;
    in_rt_data = 8'h99; in_rd = 5'd5; in_mem_write = 1;
    push(8'h30, 8'h3C, 5'd5, 0, 0, 0, 0, 1, 1);
    tick(1);

    for (int i = 0; i < 9; i++) begin
      idle_in();
      in_valid = 1; in_alu_op = t_op[i]; in_rs_data = 8'hA5;
      in_rt_data = 8'h3C; in_rd = 5'd31; in_reg_write = 1;
      push(t_res[i], 8'h3C, 5'd31, t_res[i] == 0, 0, 1, 0, 0, 1);
      tick(1);
    end

    // stall beats flush; then flush alone gives a bubble
    idle_in();
    in_valid = 1; in_alu_op = 0; in_rs_data = 8'h11; in_rd = 5'd6;
    mem_stall = 1; flush = 1;
    @(posedge clk); #1;
    chk("stall_valid", 32'(ex_mem_valid), 1);
    chk("stall_result", 32'(ex_mem_result), 32'h69);
    mem_stall = 0;
    tick(0);
    chk("flush_hold_result", 32'(ex_mem_result), 32'h69);

    // MUL 0x0D * 0x0B, forwarding inputs toggled during RUN
    set_mul(5'd7);
    #1 chk("busy_mul_T", 32'(ex_busy), 1);
    push(8'h8F, 8'h00, 5'd7, 0, 0, 1, 0, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      tick(0);
      forward_a = 2'b10;
      mem_fwd_data = 8'(i * 37);
      #1 chk("busy_run", 32'(ex_busy), 32'(i < 8));
    end
    tick(1);
    idle_in();
    #1 chk("busy_after_mul", 32'(ex_busy), 0);

    // MUL with a 3-cycle mem_stall mid-RUN
    set_mul(5'd9);
    push(8'h8F, 8'h00, 5'd9, 0, 0, 1, 0, 0, 0);
    tick(0);
    for (int c = 1; c <= 11; c++) begin
      mem_stall = (c >= 4 && c <= 6);
      #1 chk("busy_stall", 32'(ex_busy), 32'(c != 11));
      tick(c == 11);
    end

    // MUL flushed at counter 4
    set_mul(5'd10);
    tick(0);
    for (int c = 1; c <= 4; c++) begin
      #1 chk("busy_pre_flush", 32'(ex_busy), 1);
      tick(0);
    end
    flush = 1; in_valid = 0;
    #1 chk("busy_flush_cycle", 32'(ex_busy), 1);
    tick(0);
    flush = 0;
    #1 chk("busy_post_flush", 32'(ex_busy), 0);
    tick(0);
    tick(0);

    // asynchronous reset mid-RUN
    set_mul(5'd11);
    tick(0);
    tick(0);
    tick(0);
    #3 rst_n = 0;
    #1;
    chk("areset_valid", 32'(ex_mem_valid), 0);
    chk("areset_result", 32'(ex_mem_result), 0);
    chk("areset_store", 32'(ex_mem_store_data), 0);
    chk("areset_rd", 32'(ex_mem_rd), 0);
    chk("areset_busy", 32'(ex_busy), 0);
    idle_in();
    in_valid = 1; in_alu_op = 0; in_rs_data = 8'h12; in_rt_data = 8'h34;
    in_rd = 5'd2; in_reg_write = 1;
    #2 rst_n = 1;
    push(8'h46, 8'h34, 5'd2, 0, 0, 1, 0, 0, 1);
    #1 chk("busy_add_post_reset", 32'(ex_busy), 0);
    tick(1);
    idle_in();
    tick(0);
    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
